// File: rtl/drum_pkg.sv
// Shared sizes, state encoding and handy types for the drum step sequencer.
package drum_pkg;

  localparam int NUM_VOICES = 4;
  localparam int NUM_STEPS  = 16;
  localparam int STEP_W     = $clog2(NUM_STEPS);
  localparam int VOICE_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PLAYING = 2'd2
  } seq_state_t;

  typedef logic [STEP_W-1:0]     step_t;
  typedef logic [NUM_VOICES-1:0] voice_mask_t;
  typedef logic [VOICE_W-1:0]    voice_t;

endpackage

// File: rtl/toggle_edge_detect.sv
// Registers the beat square wave and flags every transition, rising or falling.
module toggle_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic beat,
  output logic tick
);

  logic beat_q;

  // Remember last cycle's beat level; cleared to 0 so a high beat right after reset is a tick.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) beat_q <= 1'b0;
    else        beat_q <= beat;
  end

  assign tick = beat ^ beat_q;

endmodule

// File: rtl/step_sequencer.sv
// Beat-driven looping step sequencer with a writable voices x steps trigger grid.
module step_sequencer
  import drum_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        beat,
  input  logic        run,
  input  logic        restart,
  input  step_t       last_step,
  input  logic        wr_en,
  input  voice_t      wr_voice,
  input  step_t       wr_step,
  input  logic        wr_data,
  output step_t       step,
  output voice_mask_t trig,
  output logic        step_tick,
  output logic        running
);

  logic                 tick;
  seq_state_t           state;
  logic [NUM_STEPS-1:0] pattern [NUM_VOICES];
  step_t                wrap_step;
  step_t                play_step;
  voice_mask_t          play_trig;

  toggle_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .beat  (beat),
    .tick  (tick)
  );

  // Pattern grid: written in any state; a wr_voice matching no row writes nothing.
  // NOTE: the grid must read back all zeros after reset, so it is built from resettable flops rather than a RAM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) pattern[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_en && wr_voice == VOICE_W'(v)) pattern[v][wr_step] <= wr_data;
      end
    end
  end

  // Choose the step the next tick plays and fetch its column, forwarding a same-cycle write.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wrap_step = (step >= last_step) ? '0 : step + step_t'(1);
    play_step = '0;
    if (state == PLAYING && !restart) play_step = wrap_step;
    play_trig = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (wr_en && wr_voice == VOICE_W'(v) && wr_step == play_step) play_trig[v] = wr_data;
      else                                                           play_trig[v] = pattern[v][play_step];
    end
  end

  // Play-control FSM; stop beats tick, tick beats a stand-alone restart.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      step      <= '0;
      trig      <= '0;
      step_tick <= 1'b0;
    end else begin
      trig      <= '0;
      step_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run) state <= ARMED;
        end
        ARMED, PLAYING: begin
          if (!run) begin
            state <= IDLE;
            step  <= '0;
          end else if (tick) begin
            state     <= PLAYING;
            step      <= play_step;
            trig      <= play_trig;
            step_tick <= 1'b1;
          end else if (restart && state == PLAYING) begin
            state <= ARMED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign running = (state != IDLE);

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench: directed scenarios plus random play against a behavioural model.
module tb_step_sequencer;
  import drum_pkg::*;

  logic        clock = 1'b0;
  logic        reset, beat, run, restart, wr_en, wr_data;
  step_t       last_step, wr_step, step;
  voice_t      wr_voice;
  voice_mask_t trig;
  logic        step_tick, running;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a grid of hits and a play position in plain ints/bits.
  bit          m_grid [NUM_VOICES][NUM_STEPS];
  bit          m_beat, m_active, m_waiting, m_tick;
  int          m_step;
  voice_mask_t m_trig;

  step_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .beat      (beat),
    .run       (run),
    .restart   (restart),
    .last_step (last_step),
    .wr_en     (wr_en),
    .wr_voice  (wr_voice),
    .wr_step   (wr_step),
    .wr_data   (wr_data),
    .step      (step),
    .trig      (trig),
    .step_tick (step_tick),
    .running   (running)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model over one clock edge using the inputs the DUT is about to sample.
  task automatic model_edge();
    bit t;
    int nxt;
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++)
        for (int s = 0; s < NUM_STEPS; s++) m_grid[v][s] = 1'b0;
      m_beat = 0; m_active = 0; m_waiting = 0; m_tick = 0; m_step = 0; m_trig = '0;
    end else begin
      t      = (beat != m_beat);
      m_beat = beat;
      if (wr_en && int'(wr_voice) < NUM_VOICES) m_grid[wr_voice][wr_step] = wr_data;
      m_trig = '0;
      m_tick = 0;
      if (!m_active) begin
        if (run) begin m_active = 1; m_waiting = 1; end
      end else if (!run) begin
        m_active = 0; m_step = 0;
      end else if (t) begin
        if (m_waiting || restart)      nxt = 0;
        else if (m_step >= last_step)  nxt = 0;
        else                           nxt = m_step + 1;
        m_step = nxt; m_waiting = 0; m_tick = 1;
        for (int v = 0; v < NUM_VOICES; v++) m_trig[v] = m_grid[v][nxt];
      end else if (restart) begin
        m_waiting = 1;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    check("step",      32'(step),      32'(m_step));
    check("trig",      32'(trig),      32'(m_trig));
    check("step_tick", 32'(step_tick), 32'(m_tick));
    check("running",   32'(running),   32'(m_active));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic beat_edge();
    beat = ~beat;
    cycle();
  endtask

  task automatic write_cell(input int v, input int s, input bit d);
    wr_en = 1; wr_voice = voice_t'(v); wr_step = step_t'(s); wr_data = d;
    cycle();
    wr_en = 0;
  endtask

  initial begin
    int exp_trig;
    reset = 0; beat = 0; run = 0; restart = 0; last_step = step_t'(15);
    wr_en = 0; wr_voice = '0; wr_step = '0; wr_data = 0;

    // 1: reset with beat toggling
    for (int i = 0; i < 3; i++) beat_edge();
    check("rst_step", 32'(step), 0);
    check("rst_trig", 32'(trig), 0);
    check("rst_running", 32'(running), 0);
    beat = 0; reset = 1;
    idle(2);

    // 2: basic pattern playback
    write_cell(0, 0, 1); write_cell(0, 4, 1); write_cell(0, 8, 1); write_cell(0, 12, 1);
    write_cell(1, 2, 1);
    run = 1;
    idle(2);
    for (int e = 1; e <= 17; e++) begin
      beat_edge();
      exp_trig = (((e - 1) % 4) == 0) ? 1 : ((e - 1) == 2) ? 2 : 0;
      check("t2_step", 32'(step), 32'((e - 1) % 16));
      check("t2_trig", 32'(trig), 32'(exp_trig));
      idle(9);
      check("t2_trig_low", 32'(trig), 0);
    end

    // 3: shortening the loop while past its end, then a one-step loop
    for (int e = 0; e < 7; e++) begin beat_edge(); idle(2); end
    check("t3_at7", 32'(step), 7);
    last_step = step_t'(3);
    for (int e = 0; e < 5; e++) begin
      beat_edge();
      check("t3_wrap", 32'(step), 32'(e % 4));
      idle(2);
    end
    last_step = '0;
    for (int e = 0; e < 3; e++) begin
      beat_edge();
      check("t3_len1_step", 32'(step), 0);
      check("t3_len1_tick", 32'(step_tick), 1);
      idle(2);
    end

    // 4: stop coincident with a tick, then restart playback
    last_step = step_t'(15);
    beat_edge(); idle(2); beat_edge(); idle(2);
    run = 0;
    beat_edge();
    check("t4_trig", 32'(trig), 0);
    check("t4_step", 32'(step), 0);
    check("t4_running", 32'(running), 0);
    run = 1;
    idle(2);
    beat_edge();
    check("t4_first", 32'(step), 0);
    check("t4_first_tick", 32'(step_tick), 1);
    idle(2);

    // 5: restart between ticks and coincident with a tick
    for (int e = 0; e < 9; e++) begin beat_edge(); idle(2); end
    check("t5_at9", 32'(step), 9);
    restart = 1; cycle(); restart = 0;
    idle(2);
    beat_edge();
    check("t5_restart", 32'(step), 0);
    idle(2);
    beat_edge(); idle(2); beat_edge(); idle(2);
    restart = 1;
    beat_edge();
    restart = 0;
    check("t5_coinc", 32'(step), 0);
    check("t5_coinc_tick", 32'(step_tick), 1);
    idle(2);

    // 6: write-through on the played cell, then reset mid-play clears the grid
    for (int e = 0; e < 4; e++) begin beat_edge(); idle(2); end
    check("t6_at4", 32'(step), 4);
    wr_en = 1; wr_voice = voice_t'(2); wr_step = step_t'(5); wr_data = 1;
    beat_edge();
    wr_en = 0;
    check("t6_step", 32'(step), 5);
    check("t6_wt", 32'(trig[2]), 1);
    idle(2);
    reset = 0;
    cycle();
    check("t6_rst_step", 32'(step), 0);
    check("t6_rst_running", 32'(running), 0);
    reset = 1;
    idle(2);
    beat_edge();
    check("t6_clr_step", 32'(step), 0);
    check("t6_clr_trig", 32'(trig), 0);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      beat    = ($urandom_range(0, 3) == 0) ? ~beat : beat;
      restart = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 49) == 0) last_step = step_t'($urandom_range(0, NUM_STEPS - 1));
      wr_en    = ($urandom_range(0, 5) == 0);
      wr_voice = voice_t'($urandom_range(0, NUM_VOICES - 1));
      wr_step  = step_t'($urandom_range(0, NUM_STEPS - 1));
      wr_data  = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Consumes the `beat` square wave from the BPM clock divider and turns it into a looping step position.
- Emits one-cycle drum-voice trigger pulses from a writable pattern grid, NUM_VOICES voices x NUM_STEPS steps.
- Sits directly downstream of the BPM divider and upstream of the per-voice sample players.
- Each transition of `beat`, rising or falling, is one step (eighth-note grid).

Parameters:
- NUM_VOICES, 4, number of drum voices (rows of pattern grid)
- NUM_STEPS, 16, steps per pattern (columns); power of two
- STEP_W, 4, width of step index, = log2(NUM_STEPS)

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next clock edge)
- beat  in  1  toggling beat from the BPM divider, same clock domain
- run  in  1  level; 1 = play, 0 = stop
- restart  in  1  one-cycle pulse; the next step tick plays step 0
- last_step  in  STEP_W  final step of the loop (pattern length = last_step+1)
- wr_en  in  1  pattern write strobe
- wr_voice  in  log2(NUM_VOICES)  voice row to write
- wr_step  in  STEP_W  step column to write
- wr_data  in  1  cell value (1 = hit)
- step  out  STEP_W  step currently sounding
- trig  out  NUM_VOICES  one-cycle hit pulses, bit v = voice v
- step_tick  out  1  one-cycle pulse on every step played
- running  out  1  1 while in ARMED or PLAYING

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, step=0, trig=0, step_tick=0, running=0, beat_q=0, pattern grid all 0. Reset wins over every other input.
- Edge detect:
  - beat_q <= beat each cycle.
  - tick = (beat != beat_q), combinational. One tick per beat transition.
  - The first sample after reset with beat==1 counts as a tick.
- Latency: trig/step/step_tick register on the clock edge ending the cycle in which tick is high, i.e. 1 clock after `beat` changes.
- State machine (seq_state_t):
  - IDLE: running=0, outputs 0. run==1 -> ARMED.
  - ARMED: running=1. On tick: step<=0, trig<=pattern[*][0], step_tick<=1, -> PLAYING. run==0 -> IDLE.
  - PLAYING: on tick: nxt = (step >= last_step) ? 0 : step+1; step<=nxt, trig<=pattern[*][nxt], step_tick<=1. run==0 -> IDLE.
- Stop: run falling forces IDLE on the next edge. step<=0, trig<=0, step_tick<=0. Stop wins over a simultaneous tick.
- restart:
  - In PLAYING without tick: -> ARMED.
  - Coincident with tick: that tick plays step 0 (state PLAYING).
  - Ignored in IDLE.
- trig and step_tick are high for exactly one cycle per tick, otherwise 0.
- Wrap: last_step may change at any time. If step > last_step, the next tick goes to 0. last_step==0 loops step 0 every tick.
- Pattern write:
  - pattern[wr_voice][wr_step] <= wr_data when wr_en, in any state.
  - Write to the cell being read on the same tick is write-through: trig reflects wr_data.
  - Out-of-range wr_voice (non-power-of-two NUM_VOICES) is ignored.
- Arithmetic: step+1 computed in STEP_W bits; the comparison with last_step handles wrap, never relying on overflow.

Decomposition:
- drum_pkg holds:
  - constants NUM_VOICES, NUM_STEPS, STEP_W
  - enum seq_state_t {IDLE, ARMED, PLAYING}
  - typedef step_t = logic [STEP_W-1:0]
  - typedef voice_mask_t = logic [NUM_VOICES-1:0]
- One sub-module, toggle_edge_detect: registers `beat` and outputs a one-cycle tick on either edge. Reset value 0, same active-low synchronous reset.
- Pattern grid and FSM stay in step_sequencer.

Test Plan:
1. Reset held low 3 cycles with beat toggling -> step=0, trig=0, running=0, grid reads all 0 afterwards.
2. Write voice0 steps {0,4,8,12}, voice1 step 2. run=1, last_step=15, beat toggling every 10 cycles -> trig=4'b0001 one cycle after beat edges 1,5,9,13; trig=4'b0010 after edge 3. step walks 0..15 then 0.
3. last_step=3 while playing at step 7 -> next tick step=0, then 1,2,3,0. last_step=0 -> step stays 0 with step_tick every tick.
4. run dropped at the same cycle as tick -> no trig, step=0, running=0 next cycle. Re-raise run -> first tick plays step 0.
5. restart pulse at step 9 between ticks -> next tick step=0. restart coincident with tick -> that tick gives step=0.
6. wr_en setting voice2 step 5 in the cycle of the tick that plays step 5 -> trig[2]=1 that step (write-through). reset driven low mid-play -> all outputs 0 and grid cleared on that edge.
